// File: rtl/fp32_stage_mul_mantissa.sv
// rtl/fp32_stage_mul_mantissa.sv - FP32 multiply mantissa stage: sliced 24x24 product, normalize, rebias
//
// Purpose:
//   Takes the registered operands of the FP32 multiply setup stage and restores
//   the hidden bits. It forms the 48-bit mantissa product one b-operand slice per
//   pipeline stage. A final registered stage normalizes the product, rebiases the
//   exponent and saturates to infinity or flushes to zero.
//   The block is fully pipelined with no backpressure.
//   Latency from valid_i to valid_o is NSLICE+1 cycles.
//
// Configuration:
//   FP32_MUL_ROUND_EN - when defined, the result fraction is rounded to
//                       nearest-even inside the normalize cycle. When
//                       undefined, the fraction is truncated.
//
// Parameters:
//   SLICE_W       - b-operand slice width per stage (4, 6, 8, 12 or 24)
//
// Ports:
//   clk           - clock
//   rst           - asynchronous active-high reset
//   flush         - synchronous; clears every in-flight valid on the next edge
//   valid_i       - operand pair valid
//   mantissa_a    - fraction of a (no hidden bit)
//   mantissa_b    - fraction of b (no hidden bit)
//   exponent_sum  - biased exponent sum exp_a+exp_b (0..510)
//   sign          - product sign
//   valid_o       - result valid
//   sign_o        - result sign
//   exponent_o    - biased result exponent
//   mantissa_o    - normalized result fraction
//   overflow_o    - result exponent >= 255 (infinity)
//   underflow_o   - result exponent <= 0 (flushed to zero)

module fp32_stage_mul_mantissa #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_i,
  input  logic [22:0] mantissa_a,
  input  logic [22:0] mantissa_b,
  input  logic [9:0]  exponent_sum,
  input  logic        sign,
  output logic        valid_o,
  output logic        sign_o,
  output logic [7:0]  exponent_o,
  output logic [22:0] mantissa_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  localparam int NSLICE = 24 / SLICE_W;

  // ---------------------------------------------------------------------------
  // Multiply pipeline: stage k adds A * B[k-th slice] << (k*SLICE_W) to the
  // running partial sum and carries operands and side-band fields along.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    logic [23:0] w_a_prev;
    logic [23:0] w_b_prev;
    logic [47:0] w_acc_prev;
    logic [9:0]  w_exp_prev;
    logic        w_sign_prev;
    logic        w_vld_prev;
    logic [47:0] w_pp;

    logic [23:0] r_a;
    logic [23:0] r_b;
    logic [47:0] r_acc;
    logic [9:0]  r_exp;
    logic        r_sign;
    logic        r_vld;

    if (k == 0) begin : g_first
      // Hidden bits restored here; zero/denormal operands are handled downstream.
      assign w_a_prev    = {1'b1, mantissa_a};
      assign w_b_prev    = {1'b1, mantissa_b};
      assign w_acc_prev  = '0;
      assign w_exp_prev  = exponent_sum;
      assign w_sign_prev = sign;
      assign w_vld_prev  = valid_i;
    end else begin : g_next
      assign w_a_prev    = g_stage[k-1].r_a;
      assign w_b_prev    = g_stage[k-1].r_b;
      assign w_acc_prev  = g_stage[k-1].r_acc;
      assign w_exp_prev  = g_stage[k-1].r_exp;
      assign w_sign_prev = g_stage[k-1].r_sign;
      assign w_vld_prev  = g_stage[k-1].r_vld;
    end

    // 24 x SLICE_W partial product, placed at its slice weight. The full sum
    // never exceeds 48 bits, so the 48-bit truncation is lossless.
    assign w_pp = ({24'd0, w_a_prev} *
                   {{(48-SLICE_W){1'b0}}, w_b_prev[k*SLICE_W +: SLICE_W]}) << (k*SLICE_W);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a    <= '0;
        r_b    <= '0;
        r_acc  <= '0;
        r_exp  <= '0;
        r_sign <= 1'b0;
        r_vld  <= 1'b0;
      end else begin
        r_a    <= w_a_prev;
        r_b    <= w_b_prev;
        r_acc  <= w_acc_prev + w_pp;
        r_exp  <= w_exp_prev;
        r_sign <= w_sign_prev;
        // flush kills the pair entering this stage, including a new valid_i.
        r_vld  <= w_vld_prev & ~flush;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Normalize stage
  // ---------------------------------------------------------------------------
  logic [47:0]        w_p;
  logic [9:0]         w_exp_sum;
  logic               w_sign;
  logic               w_vld;
  logic [22:0]        w_frac;
  logic               w_guard;
  logic               w_sticky;
  logic signed [10:0] w_e;
  logic [22:0]        w_frac_fin;
  logic signed [10:0] w_e_fin;
  logic               w_ovf;
  logic               w_unf;
  logic               w_load;

  assign w_p       = g_stage[NSLICE-1].r_acc;
  assign w_exp_sum = g_stage[NSLICE-1].r_exp;
  assign w_sign    = g_stage[NSLICE-1].r_sign;
  assign w_vld     = g_stage[NSLICE-1].r_vld;

  // Product of two [1,2) values lies in [1,4): bit 47 selects the extra shift.
  always_comb begin
    w_frac   = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_e      = '0;
    if (w_p[47]) begin
      w_frac   = w_p[46:24];
      w_guard  = w_p[23];
      w_sticky = |w_p[22:0];
      w_e      = $signed({1'b0, w_exp_sum}) - 11'sd126;
    end else begin
      w_frac   = w_p[45:23];
      w_guard  = w_p[22];
      w_sticky = |w_p[21:0];
      w_e      = $signed({1'b0, w_exp_sum}) - 11'sd127;
    end
  end

`ifdef FP32_MUL_ROUND_EN
  // Round to nearest, ties to even. A carry out of the fraction leaves the low
  // 23 bits at zero and bumps the exponent.
  logic        w_round_up;
  logic [23:0] w_frac_inc;

  assign w_round_up = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_inc = {1'b0, w_frac} + {23'd0, w_round_up};
  assign w_frac_fin = w_frac_inc[22:0];
  assign w_e_fin    = w_e + $signed({10'd0, w_frac_inc[23]});
`else
  // Truncation: guard and sticky are intentionally discarded.
  logic w_unused_rnd;

  assign w_unused_rnd = w_guard ^ w_sticky;
  assign w_frac_fin   = w_frac;
  assign w_e_fin      = w_e;
`endif

  assign w_ovf  = (w_e_fin >= 11'sd255);
  assign w_unf  = (w_e_fin <= 11'sd0);
  assign w_load = w_vld & ~flush;

  // Operand copies leaving the last stage feed nothing further.
  logic w_unused_ops;
  assign w_unused_ops = ^{g_stage[NSLICE-1].r_a, g_stage[NSLICE-1].r_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o     <= 1'b0;
      sign_o      <= 1'b0;
      exponent_o  <= '0;
      mantissa_o  <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      valid_o <= w_load;
      // Data outputs only move with a valid result so they hold while idle.
      if (w_load) begin
        sign_o      <= w_sign;
        overflow_o  <= w_ovf;
        underflow_o <= w_unf;
        if (w_ovf) begin
          exponent_o <= 8'hFF;
          mantissa_o <= '0;
        end else if (w_unf) begin
          exponent_o <= 8'h00;
          mantissa_o <= '0;
        end else begin
          exponent_o <= w_e_fin[7:0];
          mantissa_o <= w_frac_fin;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_stage_mul_mantissa.sv
// tb/tb_fp32_stage_mul_mantissa.sv - self-checking bench for fp32_stage_mul_mantissa

module tb_fp32_stage_mul_mantissa;

  localparam int SLICE_W = 8;
  localparam int NSLICE  = 24 / SLICE_W;
  localparam int LAT     = NSLICE + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid_i = 1'b0;
  logic [22:0] mantissa_a = '0;
  logic [22:0] mantissa_b = '0;
  logic [9:0]  exponent_sum = '0;
  logic        sign = 1'b0;
  logic        valid_o;
  logic        sign_o;
  logic [7:0]  exponent_o;
  logic [22:0] mantissa_o;
  logic        overflow_o;
  logic        underflow_o;

  fp32_stage_mul_mantissa #(.SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i),
    .mantissa_a(mantissa_a), .mantissa_b(mantissa_b),
    .exponent_sum(exponent_sum), .sign(sign),
    .valid_o(valid_o), .sign_o(sign_o), .exponent_o(exponent_o),
    .mantissa_o(mantissa_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        ov;
    logic        un;
    int          cyc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(logic s, logic [7:0] e, logic [22:0] m, logic ov, logic un);
    exp_t r;
    r.s = s; r.e = e; r.m = m; r.ov = ov; r.un = un; r.cyc = 0;
    return r;
  endfunction

  // Reference: exact product, normalize by magnitude, optional RNE, clamp.
  function automatic exp_t model(logic [22:0] ma, logic [22:0] mb, logic [9:0] es, logic s);
    longint unsigned a, b, p, frac, rem, half;
    int e;
    exp_t r;
    a = 64'h800000 + 64'(ma);
    b = 64'h800000 + 64'(mb);
    p = a * b;
    e = int'(es) - 127;
    if (p >= (64'd1 << 47)) begin
      e++;
      frac = (p >> 24) & 64'h7FFFFF;
      rem  = p & 64'hFFFFFF;
      half = 64'h800000;
    end else begin
      frac = (p >> 23) & 64'h7FFFFF;
      rem  = p & 64'h7FFFFF;
      half = 64'h400000;
    end
`ifdef FP32_MUL_ROUND_EN
    if (rem > half || (rem == half && (frac % 2) == 1)) frac++;
    if (frac == 64'h800000) begin
      frac = 0;
      e++;
    end
`else
    if (rem > half) rem = 0;
`endif
    if (e >= 255)    r = mk(s, 8'hFF, 23'd0, 1'b1, 1'b0);
    else if (e <= 0) r = mk(s, 8'h00, 23'd0, 1'b0, 1'b1);
    else             r = mk(s, 8'(e), 23'(frac), 1'b0, 1'b0);
    return r;
  endfunction

  task automatic drive(input logic v, input logic f, input logic [22:0] ma, input logic [22:0] mb,
                       input logic [9:0] es, input logic s);
    @(posedge clk);
    #1;
    valid_i = v; flush = f; mantissa_a = ma; mantissa_b = mb; exponent_sum = es; sign = s;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 23'd0, 23'd0, 10'd0, 1'b0);
  endtask

  task automatic send_exp(input logic [22:0] ma, input logic [22:0] mb, input logic [9:0] es,
                          input logic s, input exp_t ex);
    drive(1'b1, 1'b0, ma, mb, es, s);
    ex.cyc = cyc;
    q.push_back(ex);
  endtask

  task automatic send(input logic [22:0] ma, input logic [22:0] mb, input logic [9:0] es, input logic s);
    send_exp(ma, mb, es, s, model(ma, mb, es, s));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) idle();
    chk("drain_empty", 48'(q.size()), 48'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, 48'(valid_o), 48'd0);
    end
  endtask

  // Scoreboard: every valid result must match the oldest expected entry.
  always @(negedge clk) begin
    if (valid_o) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 48'(valid_o), 48'd0);
      end else begin
        exp_t ex;
        ex = q.pop_front();
        chk("latency",     48'(cyc - ex.cyc), 48'(LAT));
        chk("sign_o",      48'(sign_o),       48'(ex.s));
        chk("exponent_o",  48'(exponent_o),   48'(ex.e));
        chk("mantissa_o",  48'(mantissa_o),   48'(ex.m));
        chk("overflow_o",  48'(overflow_o),   48'(ex.ov));
        chk("underflow_o", 48'(underflow_o),  48'(ex.un));
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid_o",     48'(valid_o),     48'd0);
    chk("rst_sign_o",      48'(sign_o),      48'd0);
    chk("rst_exponent_o",  48'(exponent_o),  48'd0);
    chk("rst_mantissa_o",  48'(mantissa_o),  48'd0);
    chk("rst_overflow_o",  48'(overflow_o),  48'd0);
    chk("rst_underflow_o", 48'(underflow_o), 48'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases
    send_exp(23'h000000, 23'h000000, 10'd254, 1'b0, mk(1'b0, 8'd127, 23'h000000, 1'b0, 1'b0));
    drain();
    send_exp(23'h400000, 23'h400000, 10'd254, 1'b0, mk(1'b0, 8'd128, 23'h100000, 1'b0, 1'b0));
    send_exp(23'h7FFFFF, 23'h7FFFFF, 10'd254, 1'b1, mk(1'b1, 8'd128, 23'h7FFFFE, 1'b0, 1'b0));
`ifdef FP32_MUL_ROUND_EN
    send_exp(23'h000001, 23'h400000, 10'd254, 1'b0, mk(1'b0, 8'd127, 23'h400002, 1'b0, 1'b0));
`else
    send_exp(23'h000001, 23'h400000, 10'd254, 1'b0, mk(1'b0, 8'd127, 23'h400001, 1'b0, 1'b0));
`endif
    send_exp(23'h123456, 23'h654321, 10'd400, 1'b1, mk(1'b1, 8'hFF, 23'd0, 1'b1, 1'b0));
    send_exp(23'h123456, 23'h654321, 10'd100, 1'b0, mk(1'b0, 8'h00, 23'd0, 1'b0, 1'b1));
    // Exponent boundaries around 1.0 * 1.0 and 1.5 * 1.5
    send_exp(23'h000000, 23'h000000, 10'd381, 1'b0, mk(1'b0, 8'hFE, 23'd0, 1'b0, 1'b0));
    send_exp(23'h000000, 23'h000000, 10'd382, 1'b0, mk(1'b0, 8'hFF, 23'd0, 1'b1, 1'b0));
    send_exp(23'h000000, 23'h000000, 10'd127, 1'b0, mk(1'b0, 8'h00, 23'd0, 1'b0, 1'b1));
    send_exp(23'h400000, 23'h400000, 10'd126, 1'b1, mk(1'b1, 8'h00, 23'd0, 1'b0, 1'b1));
    drain();

    // 16 back-to-back random pairs, then a longer random mix near the edges
    for (int i = 0; i < 16; i++)
      send(23'($urandom), 23'($urandom), 10'($urandom_range(510, 0)), 1'($urandom));
    drain();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) == 0) idle();
      else send(23'($urandom), 23'($urandom), 10'($urandom_range(260, 120)), 1'($urandom));
    end
    drain();

    // Reset two cycles after a valid_i: the pair is lost
    drive(1'b1, 1'b0, 23'h222222, 23'h333333, 10'd254, 1'b1);
    idle();
    idle();
    rst = 1'b1;
    expect_quiet("rst_drop_valid", 2);
    @(posedge clk);
    #1 rst = 1'b0;
    expect_quiet("rst_drop_valid", LAT + 2);

    // Flush one cycle after a valid_i: the pair is lost
    drive(1'b1, 1'b0, 23'h0ABCDE, 23'h1FEDCB, 10'd254, 1'b0);
    drive(1'b0, 1'b1, 23'd0, 23'd0, 10'd0, 1'b0);
    idle();
    expect_quiet("flush_drop_valid", LAT + 2);

    // valid_i together with flush: dropped
    drive(1'b1, 1'b1, 23'h0ABCDE, 23'h1FEDCB, 10'd254, 1'b0);
    idle();
    expect_quiet("flush_same_cycle", LAT + 2);

    // A pair after the flush comes through with normal latency
    drive(1'b1, 1'b0, 23'h111111, 23'h222222, 10'd254, 1'b0);
    drive(1'b0, 1'b1, 23'd0, 23'd0, 10'd0, 1'b0);
    send(23'h400000, 23'h400000, 10'd254, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
